// File: rtl/buffer_stream_reader_if.sv
// Row stream from the buffer reader to its consumer: valid/ready handshake
// carrying one buffer row plus an end-of-command marker.
interface buffer_stream_reader_if #(
  parameter int unsigned WIDTH = 384
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             last;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );
endinterface

// File: rtl/buffer_stream_reader.sv
// Read-side sequencer: walks a wrap-around row range of the register-file buffer and streams
// each row downstream at one row per cycle. Optional multi-pass replay under BUF_RD_REPEAT_EN.
module buffer_stream_reader #(
  parameter int unsigned WIDTH  = 384,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned LEN_W  = $clog2(DEPTH + 1)
`ifdef BUF_RD_REPEAT_EN
  ,
  parameter int unsigned RPT_W  = 4
`endif
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [ADDR_W-1:0]      i_base_addr,
  input  logic [LEN_W-1:0]       i_len,
`ifdef BUF_RD_REPEAT_EN
  input  logic [RPT_W-1:0]       i_repeat,
`endif
  output logic                   o_busy,
  output logic                   o_done,
  output logic [ADDR_W-1:0]      o_addr_rd,
  input  logic [WIDTH-1:0]       i_data_rd,
  buffer_stream_reader_if.master strm
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] ptr_next;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              load;
  logic              final_pass;
  logic              last_row;

`ifdef BUF_RD_REPEAT_EN
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [RPT_W-1:0]  pass_q, pass_d;

  assign final_pass = (pass_q == '0);
`else
  assign final_pass = 1'b1;
`endif

  // Explicit wrap keeps non-power-of-two depths correct.
  assign ptr_next = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + ADDR_W'(1);
  assign last_row = (remaining_q == LEN_W'(1));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    valid_d     = valid_q;
    last_d      = last_q;
    data_d      = data_q;
    done_d      = 1'b0;
    load        = 1'b0;
`ifdef BUF_RD_REPEAT_EN
    base_d      = base_q;
    len_d       = len_q;
    pass_d      = pass_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          if (i_len != '0) begin
            ptr_d       = i_base_addr;
            remaining_d = i_len;
            state_d     = StRun;
`ifdef BUF_RD_REPEAT_EN
            base_d      = i_base_addr;
            len_d       = i_len;
            pass_d      = i_repeat;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end

      StRun: begin
        // Output register is free when empty or being drained this cycle.
        load = !valid_q || strm.ready;
        if (load) begin
          data_d      = i_data_rd;
          valid_d     = 1'b1;
          last_d      = last_row && final_pass;
          ptr_d       = ptr_next;
          remaining_d = remaining_q - LEN_W'(1);
          if (last_row) begin
            if (final_pass) begin
              state_d = StDrain;
            end
`ifdef BUF_RD_REPEAT_EN
            else begin
              // Next pass starts on the very next load: no bubble.
              ptr_d       = base_q;
              remaining_d = len_q;
              pass_d      = pass_q - RPT_W'(1);
            end
`endif
          end
        end
      end

      StDrain: begin
        if (valid_q && strm.ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      remaining_q <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= '0;
`ifdef BUF_RD_REPEAT_EN
      base_q      <= '0;
      len_q       <= '0;
      pass_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      done_q      <= done_d;
      data_q      <= data_d;
`ifdef BUF_RD_REPEAT_EN
      base_q      <= base_d;
      len_q       <= len_d;
      pass_q      <= pass_d;
`endif
    end
  end

  assign o_busy     = (state_q != StIdle);
  assign o_done     = done_q;
  assign o_addr_rd  = ptr_q;
  assign strm.valid = valid_q;
  assign strm.data  = data_q;
  assign strm.last  = last_q;

endmodule
